// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage miniRV pipeline: tracks in-flight writers in EX/MEM/WB
// and produces stall, flush and operand-forwarding controls plus saturating event counters.
module hazard_sched #(
    parameter int          CNT_W   = 32,
    parameter logic [1:0]  WB_DREM = 2'b01
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_read1,
    input  logic             id_read2,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic [1:0]       id_rf_wsel,
    input  logic             ex_redirect,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } sb_entry_t;

    sb_entry_t ex_e, mem_e, wb_e, id_e;

    logic ex_hit1, mem_hit1, wb_hit1;
    logic ex_hit2, mem_hit2, wb_hit2;
    logic luse;

    function automatic logic hit(input sb_entry_t e, input logic [4:0] rs, input logic rd_en);
        return e.v & e.we & (e.rd == rs) & rd_en & (rs != 5'd0);
    endfunction

    // Nearest in-flight writer wins, so EX beats MEM beats WB.
    function automatic logic [1:0] pick(input logic h_ex, input logic h_mem, input logic h_wb);
        if (h_ex)
            return 2'd1;
        else if (h_mem)
            return 2'd2;
        else if (h_wb)
            return 2'd3;
        else
            return 2'd0;
    endfunction

    always_comb begin
        id_e.v  = id_valid;
        id_e.rd = id_rd;
        id_e.we = id_rf_we & (id_rd != 5'd0);
        id_e.ld = (id_rf_wsel == WB_DREM);
    end

    always_comb begin
        ex_hit1  = hit(ex_e,  id_rs1, id_read1);
        mem_hit1 = hit(mem_e, id_rs1, id_read1);
        wb_hit1  = hit(wb_e,  id_rs1, id_read1);
        ex_hit2  = hit(ex_e,  id_rs2, id_read2);
        mem_hit2 = hit(mem_e, id_rs2, id_read2);
        wb_hit2  = hit(wb_e,  id_rs2, id_read2);
        luse     = ex_e.ld & (ex_hit1 | ex_hit2) & id_valid;
        fwd_rs1_sel = pick(ex_hit1, mem_hit1, wb_hit1);
        fwd_rs2_sel = pick(ex_hit2, mem_hit2, wb_hit2);
    end

    // A redirect squashes the ID instruction, so it overrides any load-use stall.
    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (luse) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            ex_e  <= '0;
            mem_e <= '0;
            wb_e  <= '0;
        end else begin
            wb_e  <= mem_e;
            mem_e <= ex_e;
            ex_e  <= flush_idex ? '0 : id_e;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (ex_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: hand-derived expectations per cycle are queued
// when an ID instruction is driven and compared once the combinational outputs settle.
module tb_hazard_sched;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_read1 = 1'b0, id_read2 = 1'b0, id_rf_we = 1'b0;
    logic [1:0]  id_rf_wsel = '0;
    logic        ex_redirect = 1'b0;
    logic        stall_pc, stall_ifid, flush_ifid, flush_idex;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0] stall_cnt, flush_cnt;

    hazard_sched dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_read1(id_read1), .id_read2(id_read2),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_rf_wsel(id_rf_wsel),
        .ex_redirect(ex_redirect), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic        stall_pc;
        logic        stall_ifid;
        logic        flush_ifid;
        logic        flush_idex;
        logic        fwd_care;
        logic [1:0]  fwd1;
        logic [1:0]  fwd2;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;
    int    expStall = 0;
    int    expFlush = 0;

    localparam logic [1:0] ALU = 2'b00;
    localparam logic [1:0] LD  = 2'b01;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one ID instruction and queues what the outputs must be in this cycle.
    task automatic applyStimulus(input string tag, input logic v, input logic [4:0] rs1, input logic r1,
                                 input logic [4:0] rs2, input logic r2, input logic [4:0] rd,
                                 input logic we, input logic [1:0] wsel, input logic redir,
                                 input logic luseExp, input logic care, input logic [1:0] f1,
                                 input logic [1:0] f2);
        exp_t e;
        id_valid = v; id_rs1 = rs1; id_read1 = r1; id_rs2 = rs2; id_read2 = r2;
        id_rd = rd; id_rf_we = we; id_rf_wsel = wsel; ex_redirect = redir;
        e = '0;
        e.flush_ifid = redir;
        e.flush_idex = redir | luseExp;
        e.stall_pc   = !redir && luseExp;
        e.stall_ifid = !redir && luseExp;
        e.fwd_care   = care;
        e.fwd1 = f1;
        e.fwd2 = f2;
        e.scnt = 32'(expStall);
        e.fcnt = 32'(expFlush);
        expQ.push_back(e);
        tagQ.push_back(tag);
        expStall += int'(e.stall_pc);
        expFlush += int'(redir);
    endtask

    task automatic checkCycle();
        exp_t  e;
        string t;
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput({t, ".stall_pc"},   32'(stall_pc),   32'(e.stall_pc));
        checkOutput({t, ".stall_ifid"}, 32'(stall_ifid), 32'(e.stall_ifid));
        checkOutput({t, ".flush_ifid"}, 32'(flush_ifid), 32'(e.flush_ifid));
        checkOutput({t, ".flush_idex"}, 32'(flush_idex), 32'(e.flush_idex));
        if (e.fwd_care) begin
            checkOutput({t, ".fwd1"}, 32'(fwd_rs1_sel), 32'(e.fwd1));
            checkOutput({t, ".fwd2"}, 32'(fwd_rs2_sel), 32'(e.fwd2));
        end
        checkOutput({t, ".stall_cnt"}, stall_cnt, e.scnt);
        checkOutput({t, ".flush_cnt"}, flush_cnt, e.fcnt);
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic r1,
                        input logic [4:0] rs2, input logic r2, input logic [4:0] rd,
                        input logic we, input logic [1:0] wsel, input logic redir,
                        input logic luseExp, input logic care, input logic [1:0] f1,
                        input logic [1:0] f2);
        @(posedge cpu_clk);
        #2;
        applyStimulus(tag, v, rs1, r1, rs2, r2, rd, we, wsel, redir, luseExp, care, f1, f2);
        #3;
        checkCycle();
    endtask

    task automatic nop(input string tag);
        step(tag, 1, 0, 1, 0, 0, 0, 1, ALU, 0, 0, 1, 0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".stall_pc"},   32'(stall_pc),    0);
        checkOutput({tag, ".stall_ifid"}, 32'(stall_ifid),  0);
        checkOutput({tag, ".flush_ifid"}, 32'(flush_ifid),  0);
        checkOutput({tag, ".flush_idex"}, 32'(flush_idex),  0);
        checkOutput({tag, ".fwd1"},       32'(fwd_rs1_sel), 0);
        checkOutput({tag, ".fwd2"},       32'(fwd_rs2_sel), 0);
        checkOutput({tag, ".stall_cnt"},  stall_cnt,        0);
        checkOutput({tag, ".flush_cnt"},  flush_cnt,        0);
    endtask

    initial begin
        #3;
        checkAllZero("reset");
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;

        // load-use: one stall cycle, then forward from MEM
        step("lw_x5",      1, 0, 1, 0, 0, 5, 1, LD,  0, 0, 1, 0, 0);
        step("add_stall",  1, 5, 1, 1, 1, 6, 1, ALU, 0, 1, 0, 0, 0);
        step("add_fwdmem", 1, 5, 1, 1, 1, 6, 1, ALU, 0, 0, 1, 2, 0);
        // back-to-back ALU forward, rs1==rs2
        step("addi_x5a",   1, 0, 1, 0, 0, 5, 1, ALU, 0, 0, 1, 0, 0);
        step("add_x5x5",   1, 5, 1, 5, 1, 6, 1, ALU, 0, 0, 1, 1, 1);
        // distance 2, 3 and 4
        step("addi_x5b",   1, 0, 1, 0, 0, 5, 1, ALU, 0, 0, 1, 0, 0);
        nop("nop_b1");
        step("sub_mem",    1, 1, 1, 5, 1, 7, 1, ALU, 0, 0, 1, 0, 2);
        step("addi_x5c",   1, 0, 1, 0, 0, 5, 1, ALU, 0, 0, 1, 0, 0);
        nop("nop_c1");
        nop("nop_c2");
        step("sub_wb",     1, 1, 1, 5, 1, 7, 1, ALU, 0, 0, 1, 0, 3);
        step("addi_x5d",   1, 0, 1, 0, 0, 5, 1, ALU, 0, 0, 1, 0, 0);
        nop("nop_d1");
        nop("nop_d2");
        nop("nop_d3");
        step("sub_rf",     1, 1, 1, 5, 1, 7, 1, ALU, 0, 0, 1, 0, 0);
        // writes to x0 never forward
        step("addi_x0",    1, 0, 1, 0, 0, 0, 1, ALU, 0, 0, 1, 0, 0);
        step("add_x0x0",   1, 0, 1, 0, 1, 1, 1, ALU, 0, 0, 1, 0, 0);
        // invalid ID never stalls, even behind a load to its source
        step("lw_x9",      1, 0, 1, 0, 0, 9, 1, LD,  0, 0, 1, 0, 0);
        step("invalid",    0, 9, 1, 9, 1, 10, 1, ALU, 0, 0, 0, 0, 0);
        step("add_x9x9",   1, 9, 1, 9, 1, 10, 1, ALU, 0, 0, 1, 2, 2);
        // same rd in EX and MEM: EX wins
        step("addi_x3a",   1, 0, 1, 0, 0, 3, 1, ALU, 0, 0, 1, 0, 0);
        step("addi_x3b",   1, 0, 1, 0, 0, 3, 1, ALU, 0, 0, 1, 0, 0);
        step("add_x3",     1, 3, 1, 0, 1, 4, 1, ALU, 0, 0, 1, 1, 0);
        // redirect beats load-use
        step("lw_x8",      1, 0, 1, 0, 0, 8, 1, LD,  0, 0, 1, 0, 0);
        step("redirect",   1, 8, 1, 8, 1, 9, 1, ALU, 1, 1, 0, 0, 0);
        nop("after_redir");
        // reset in the middle of a stall
        step("lw_x5r",     1, 0, 1, 0, 0, 5, 1, LD,  0, 0, 1, 0, 0);
        step("stall_r",    1, 5, 1, 1, 1, 6, 1, ALU, 0, 1, 0, 0, 0);
        #1 cpu_rst_n = 1'b0;
        #1 checkAllZero("async_rst");
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        expStall = 0;
        expFlush = 0;
        step("post_rst",   1, 5, 1, 1, 1, 6, 1, ALU, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
